fft_mag_pipe: RTL

Pipelined, parametrised magnitude stage between the FFT core and the spectrogram colour mapper. It accepts one signed complex bin per handshake and takes absolute values of both parts, with correct handling of zero and the most-negative code. It then produces an unsigned magnitude in one of four selectable modes, tags each result with its bin index, and reports the per-frame peak bin for display auto-scaling.

---
 rtl/fft_mag_pipe.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/fft_mag_pipe.sv
// Three-stage complex-magnitude pipeline: absolute values, max/min sort, mode-selected
// magnitude; tags each bin with its index and reports the per-frame peak bin.
module fft_mag_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  input  logic             in_last,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_mag,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             peak_valid,
  output logic [WIDTH:0]   peak_mag,
  output logic [IDX_W-1:0] peak_idx
);

  logic             w_adv;
  logic             w_in_hs;
  logic             w_out_hs;
  logic [WIDTH-1:0] w_abs_re;
  logic [WIDTH-1:0] w_abs_im;
  logic [1:0]       w_mode_cur;
  logic [WIDTH:0]   w_mx_ext;
  logic [WIDTH:0]   w_mn_ext;
  logic [WIDTH:0]   w_mag;
  logic             w_pk_take;
  logic [WIDTH:0]   w_pk_mag;
  logic [IDX_W-1:0] w_pk_idx;

  logic [IDX_W-1:0] r_idx;
  logic [1:0]       r_mode;

  logic             r_s1_v;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [IDX_W-1:0] r_s1_idx;
  logic             r_s1_last;
  logic [1:0]       r_s1_mode;

  logic             r_s2_v;
  logic [WIDTH-1:0] r_s2_a;
  logic [WIDTH-1:0] r_s2_b;
  logic [WIDTH-1:0] r_s2_mx;
  logic [WIDTH-1:0] r_s2_mn;
  logic [IDX_W-1:0] r_s2_idx;
  logic             r_s2_last;
  logic [1:0]       r_s2_mode;

  logic             r_out_v;
  logic [WIDTH:0]   r_out_mag;
  logic [IDX_W-1:0] r_out_idx;
  logic             r_out_last;

  logic             r_pk_arm;
  logic [WIDTH:0]   r_pk_mag;
  logic [IDX_W-1:0] r_pk_idx;
  logic             r_peak_v;
  logic [WIDTH:0]   r_peak_mag;
  logic [IDX_W-1:0] r_peak_idx;

  assign w_adv    = !r_out_v || out_ready;
  assign in_ready = w_adv;
  assign w_in_hs  = in_valid && w_adv;
  assign w_out_hs = r_out_v && out_ready;

  // Two's-complement negate in WIDTH bits: the most-negative code lands on 2^(WIDTH-1) exactly.
  assign w_abs_re = in_re[WIDTH-1] ? (~in_re) + {{(WIDTH-1){1'b0}}, 1'b1} : in_re;
  assign w_abs_im = in_im[WIDTH-1] ? (~in_im) + {{(WIDTH-1){1'b0}}, 1'b1} : in_im;

  // The first bin of a frame uses the live mode input, the same value that gets latched.
  assign w_mode_cur = (r_idx == '0) ? mode : r_mode;

  assign w_mx_ext = {1'b0, r_s2_mx};
  assign w_mn_ext = {1'b0, r_s2_mn};

  always_comb begin
    w_mag = '0;
    case (r_s2_mode)
      2'd0:    w_mag = {1'b0, r_s2_a};
      2'd1:    w_mag = {1'b0, r_s2_a} + {1'b0, r_s2_b};
      2'd2:    w_mag = w_mx_ext + (w_mn_ext >> 2) + (w_mn_ext >> 3);
      default: w_mag = w_mx_ext;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_mode <= '0;
    end else if (w_in_hs) begin
      r_idx <= in_last ? '0 : r_idx + 1'b1;
      if (r_idx == '0) r_mode <= mode;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_v     <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_idx   <= '0;
      r_s1_last  <= 1'b0;
      r_s1_mode  <= '0;
      r_s2_v     <= 1'b0;
      r_s2_a     <= '0;
      r_s2_b     <= '0;
      r_s2_mx    <= '0;
      r_s2_mn    <= '0;
      r_s2_idx   <= '0;
      r_s2_last  <= 1'b0;
      r_s2_mode  <= '0;
      r_out_v    <= 1'b0;
      r_out_mag  <= '0;
      r_out_idx  <= '0;
      r_out_last <= 1'b0;
    end else if (w_adv) begin
      r_s1_v     <= w_in_hs;
      r_s1_a     <= w_abs_re;
      r_s1_b     <= w_abs_im;
      r_s1_idx   <= r_idx;
      r_s1_last  <= in_last;
      r_s1_mode  <= w_mode_cur;
      r_s2_v     <= r_s1_v;
      r_s2_a     <= r_s1_a;
      r_s2_b     <= r_s1_b;
      r_s2_mx    <= (r_s1_a >= r_s1_b) ? r_s1_a : r_s1_b;
      r_s2_mn    <= (r_s1_a >= r_s1_b) ? r_s1_b : r_s1_a;
      r_s2_idx   <= r_s1_idx;
      r_s2_last  <= r_s1_last;
      r_s2_mode  <= r_s1_mode;
      r_out_v    <= r_s2_v;
      r_out_mag  <= w_mag;
      r_out_idx  <= r_s2_idx;
      r_out_last <= r_s2_last;
    end
  end

  // Strictly-greater replacement keeps the earliest index on ties.
  assign w_pk_take = r_pk_arm || (r_out_mag > r_pk_mag);
  assign w_pk_mag  = w_pk_take ? r_out_mag : r_pk_mag;
  assign w_pk_idx  = w_pk_take ? r_out_idx : r_pk_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pk_arm   <= 1'b1;
      r_pk_mag   <= '0;
      r_pk_idx   <= '0;
      r_peak_v   <= 1'b0;
      r_peak_mag <= '0;
      r_peak_idx <= '0;
    end else begin
      r_peak_v <= 1'b0;
      if (w_out_hs) begin
        r_pk_mag <= w_pk_mag;
        r_pk_idx <= w_pk_idx;
        r_pk_arm <= r_out_last;
        if (r_out_last) begin
          r_peak_v   <= 1'b1;
          r_peak_mag <= w_pk_mag;
          r_peak_idx <= w_pk_idx;
        end
      end
    end
  end

  assign out_valid  = r_out_v;
  assign out_mag    = r_out_mag;
  assign out_idx    = r_out_idx;
  assign out_last   = r_out_last;
  assign peak_valid = r_peak_v;
  assign peak_mag   = r_peak_mag;
  assign peak_idx   = r_peak_idx;

endmodule
